// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: channel states and divisor floor.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;

  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, run/drain FSM and a shadow divisor that is
// only applied at a period boundary, on SYNC, or while idle.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DIV_RST = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SYNC,
  input  logic             DIV_LD,
  input  logic [CNT_W-1:0] DIV_IN,
  output logic             CLKOUT,
  output logic             TICK,
  output logic             DIV_PEND
);

  ch_state_e        st_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pend_q;
  logic             pflag_q;
  logic             clk_q;
  logic             tick_q;

  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] nxt_div;
  logic [CNT_W-1:0] hi;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_end;

  always_comb begin
    ld_val  = (DIV_IN < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : DIV_IN;
    // A load on the same cycle as a period start governs that new period.
    nxt_div = DIV_LD ? ld_val : pend_q;
    hi      = div_q - (div_q >> 1);
    cnt_inc = cnt_q + CNT_W'(1);
    at_end  = (cnt_q == div_q - CNT_W'(1));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= CNT_W'(DIV_RST);
      pend_q  <= CNT_W'(DIV_RST);
      pflag_q <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (DIV_LD) begin
        pend_q  <= ld_val;
        pflag_q <= 1'b1;
      end

      unique case (st_q)
        ST_IDLE: begin
          cnt_q <= '0;
          clk_q <= 1'b0;
          if (EN) begin
            st_q    <= ST_RUN;
            clk_q   <= 1'b1;
            tick_q  <= 1'b1;
            div_q   <= nxt_div;
            pflag_q <= 1'b0;
          end else if (pflag_q) begin
            // Idle channels adopt a waiting divisor straight away.
            div_q <= pend_q;
            if (!DIV_LD) pflag_q <= 1'b0;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (SYNC || (at_end && EN)) begin
            st_q    <= EN ? ST_RUN : ST_DRAIN;
            cnt_q   <= '0;
            clk_q   <= 1'b1;
            tick_q  <= 1'b1;
            div_q   <= nxt_div;
            pflag_q <= 1'b0;
          end else if (at_end) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            div_q   <= nxt_div;
            pflag_q <= 1'b0;
          end else begin
            st_q  <= EN ? ST_RUN : ST_DRAIN;
            cnt_q <= cnt_inc;
            clk_q <= (cnt_inc < hi);
          end
        end

        default: begin
          st_q  <= ST_IDLE;
          cnt_q <= '0;
          clk_q <= 1'b0;
        end
      endcase
    end
  end

  assign CLKOUT   = clk_q;
  assign TICK     = tick_q;
  assign DIV_PEND = pflag_q;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent clock dividers off CLK, sharing only reset and the phase-align SYNC.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DIV_RST = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_CH-1:0]       EN,
  input  logic                    SYNC,
  input  logic [NUM_CH-1:0]       DIV_LD,
  input  logic [NUM_CH*CNT_W-1:0] DIV_IN,
  output logic [NUM_CH-1:0]       CLKOUT,
  output logic [NUM_CH-1:0]       TICK,
  output logic [NUM_CH-1:0]       DIV_PEND
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .CNT_W  (CNT_W),
      .DIV_RST(DIV_RST)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN[i]),
      .SYNC    (SYNC),
      .DIV_LD  (DIV_LD[i]),
      .DIV_IN  (DIV_IN[i*CNT_W +: CNT_W]),
      .CLKOUT  (CLKOUT[i]),
      .TICK    (TICK[i]),
      .DIV_PEND(DIV_PEND[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed and random checks of clk_div_multi against a period-position reference model.
module tb_clk_div_multi;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int DIV_RST = 4;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic                    sync;
  logic [NUM_CH-1:0]       div_ld;
  logic [NUM_CH*CNT_W-1:0] div_in;
  logic [NUM_CH-1:0]       CLKOUT;
  logic [NUM_CH-1:0]       TICK;
  logic [NUM_CH-1:0]       DIV_PEND;

  int total = 0;
  int bad   = 0;

  clk_div_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DIV_RST(DIV_RST)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .EN      (en),
    .SYNC    (sync),
    .DIV_LD  (div_ld),
    .DIV_IN  (div_in),
    .CLKOUT  (CLKOUT),
    .TICK    (TICK),
    .DIV_PEND(DIV_PEND)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each channel is either stopped or at position m_pos within a period of m_d.
  bit m_act [NUM_CH];
  int m_pos [NUM_CH];
  int m_d   [NUM_CH];
  int m_pend[NUM_CH];
  bit m_pf  [NUM_CH];

  function automatic int clampv(int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i] = 0; m_pos[i] = 0; m_d[i] = DIV_RST; m_pend[i] = DIV_RST; m_pf[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      int nv;
      bit ld;
      ld = div_ld[i];
      nv = ld ? clampv(int'(div_in[i*CNT_W +: CNT_W])) : m_pend[i];
      if (!m_act[i]) begin
        if (en[i]) begin
          m_act[i] = 1; m_pos[i] = 0; m_d[i] = nv; m_pend[i] = nv; m_pf[i] = 0;
        end else begin
          if (m_pf[i]) m_d[i] = m_pend[i];
          m_pf[i]   = ld;
          m_pend[i] = nv;
        end
      end else if (sync || m_pos[i] == m_d[i] - 1) begin
        m_pos[i] = 0; m_d[i] = nv; m_pend[i] = nv; m_pf[i] = 0;
        if (!sync && !en[i]) m_act[i] = 0;
      end else begin
        m_pos[i]++;
        m_pend[i] = nv;
        if (ld) m_pf[i] = 1;
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_clk();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++)
      v[i] = m_act[i] && (m_pos[i] < m_d[i] - m_d[i] / 2);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_tick();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_act[i] && (m_pos[i] == 0);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_pend();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_pf[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [NUM_CH-1:0] got,
                     input logic [NUM_CH-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    #1;
    chk("clkout", CLKOUT, exp_clk());
    chk("tick", TICK, exp_tick());
    chk("div_pend", DIV_PEND, exp_pend());
  endtask

  initial begin
    bit found;
    rst = 1'b0; en = '0; sync = 1'b0; div_ld = '0; div_in = '0;
    model_reset();
    #12;
    chk("reset_clkout", CLKOUT, '0);
    chk("reset_tick", TICK, '0);
    chk("reset_pend", DIV_PEND, '0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();

    // ch0 at reset divisor 4: 1100 repeating, tick on each rise
    en[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk_bit("ch0_d4_clk", CLKOUT[0], (k % 4) < 2);
      chk_bit("ch0_d4_tick", TICK[0], (k % 4) == 0);
    end

    // ch1: load 5 mid-period, then clamp of 0 to 2 on a boundary cycle
    en[1] = 1'b1;
    cycle();
    cycle();
    div_ld[1] = 1'b1;
    div_in[1*CNT_W +: CNT_W] = 16'd5;
    cycle();
    div_ld[1] = 1'b0;
    chk_bit("ch1_pend_after_ld", DIV_PEND[1], 1'b1);
    cycle();
    chk_bit("ch1_pend_hold", DIV_PEND[1], 1'b1);
    chk_bit("ch1_old_period_low", CLKOUT[1], 1'b0);
    cycle();
    chk_bit("ch1_pend_cleared", DIV_PEND[1], 1'b0);
    chk_bit("ch1_boundary_rise", CLKOUT[1], 1'b1);
    for (int k = 1; k < 10; k++) begin
      cycle();
      chk_bit("ch1_d5_clk", CLKOUT[1], (k % 5) < 3);
    end
    div_ld[1] = 1'b1;
    div_in[1*CNT_W +: CNT_W] = 16'd0;
    cycle();
    div_ld[1] = 1'b0;
    chk_bit("ch1_ld_on_boundary_pend", DIV_PEND[1], 1'b0);
    chk_bit("ch1_d2_start", CLKOUT[1], 1'b1);
    for (int k = 1; k < 7; k++) begin
      cycle();
      chk_bit("ch1_d2_clk", CLKOUT[1], (k % 2) == 0);
    end

    // ch2: idle load of 6, run, drop EN at cnt=1, re-enable
    div_ld[2] = 1'b1;
    div_in[2*CNT_W +: CNT_W] = 16'd6;
    cycle();
    div_ld[2] = 1'b0;
    chk_bit("ch2_idle_pend", DIV_PEND[2], 1'b1);
    cycle();
    chk_bit("ch2_idle_pend_clr", DIV_PEND[2], 1'b0);
    en[2] = 1'b1;
    cycle();
    chk_bit("ch2_en_latency", CLKOUT[2], 1'b1);
    cycle();
    en[2] = 1'b0;
    for (int k = 2; k < 6; k++) begin
      cycle();
      chk_bit("ch2_drain_clk", CLKOUT[2], k < 3);
    end
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk_bit("ch2_idle_clk", CLKOUT[2], 1'b0);
      chk_bit("ch2_idle_tick", TICK[2], 1'b0);
    end
    en[2] = 1'b1;
    cycle();
    chk_bit("ch2_reen_clk", CLKOUT[2], 1'b1);

    // ch0 and ch3 two cycles apart, then SYNC aligns them
    found = 0;
    for (int j = 0; j < 4 && !found; j++) begin
      cycle();
      if (TICK[0]) found = 1;
    end
    chk_bit("ch0_tick_seen", found, 1'b1);
    cycle();
    en[3] = 1'b1;
    cycle();
    chk_bit("skew_ch0", CLKOUT[0], 1'b0);
    chk_bit("skew_ch3", CLKOUT[3], 1'b1);
    cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    chk_bit("sync_tick0", TICK[0], 1'b1);
    chk_bit("sync_tick3", TICK[3], 1'b1);
    chk_bit("sync_clk0", CLKOUT[0], 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk_bit("aligned_clk", CLKOUT[3], CLKOUT[0]);
      chk_bit("aligned_clk_pat", CLKOUT[3], ((k + 1) % 4) < 2);
    end

    // async reset during a high phase, resume at DIV_RST with EN held
    found = 0;
    for (int j = 0; j < 4 && !found; j++) begin
      cycle();
      if (TICK[0]) found = 1;
    end
    chk_bit("ch0_tick_seen2", found, 1'b1);
    chk_bit("ch0_high_before_rst", CLKOUT[0], 1'b1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_clkout", CLKOUT, '0);
    chk("async_rst_tick", TICK, '0);
    chk("async_rst_pend", DIV_PEND, '0);
    cycle();
    cycle();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk_bit("post_rst_d4", CLKOUT[0], (k % 4) < 2);
    end

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(15, 0) == 0) en[i] = ~en[i];
        div_ld[i] = ($urandom_range(7, 0) == 0);
        div_in[i*CNT_W +: CNT_W] = 16'($urandom_range(9, 0));
      end
      sync = ($urandom_range(39, 0) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider.
- Generates NUM_CH independent divided clocks from the 100 MHz board clock, plus one-cycle TICK strobes for logic that stays on CLK.
- Each channel has a runtime-programmable ratio, applied glitch-free at a period boundary, a clean enable/disable, and a global phase-align SYNC.
- Sits at the top level feeding display scan, game-tick and VGA-timing logic.

Parameters:
- NUM_CH, 4, number of divider channels (>=1).
- CNT_W, 16, width of divisor and period counter.
- DIV_RST, 4, divisor loaded into every channel at reset (2..2^CNT_W-1).

Ports:
- CLK  input  1  system clock, 100 MHz, all logic on posedge.
- RST  input  1  asynchronous, active-low reset; 0 resets everything immediately.
- EN  input  NUM_CH  per-channel run enable, level.
- SYNC  input  1  one-cycle pulse; restarts all running channels in phase.
- DIV_LD  input  NUM_CH  per-channel one-cycle load strobe.
- DIV_IN  input  NUM_CH*CNT_W  flattened divisors; channel i uses bits [i*CNT_W +: CNT_W].
- CLKOUT  output  NUM_CH  divided clock per channel, registered.
- TICK  output  NUM_CH  one-cycle strobe at each period start, registered.
- DIV_PEND  output  NUM_CH  1 while a loaded divisor is waiting to be applied.

Behaviour:
Reset (RST=0, async):
- CLKOUT=0, TICK=0, DIV_PEND=0.
- cnt=0, active divisor d=DIV_RST, pending=DIV_RST.
- Channel state = IDLE.
Divisor rules:
- d in 2..2^CNT_W-1; DIV_IN values 0 or 1 clamp to 2 at capture.
- HI = d - (d>>1) = ceil(d/2) cycles high; low time = d>>1 cycles.
- Odd d therefore gives a high phase one cycle longer than the low phase.
Per-channel state machine (IDLE, RUN, DRAIN):
- IDLE: CLKOUT=0, TICK=0. On a cycle with EN=1, the next edge gives cnt=0, CLKOUT=1, TICK=1, and the channel enters RUN.
  - Latency: EN high to CLKOUT high = 1 clock.
- RUN: each edge cnt<=cnt+1 and CLKOUT<=(cnt+1 < HI).
  - At cnt==d-1 (boundary): cnt<=0, CLKOUT<=1, TICK<=1, and the pending divisor, if any, becomes d.
  - EN=0 sampled in RUN moves the channel to DRAIN; the current period still completes.
- DRAIN: counts like RUN; no new period is started.
  - At the boundary: with EN=1, behave as RUN (restart period, TICK=1, state RUN); with EN=0, state IDLE, CLKOUT=0, TICK=0, cnt=0.
  - EN re-asserted mid-DRAIN returns the channel to RUN with no phase disturbance.
- Never a CLKOUT pulse shorter than min(HI, d>>1) cycles: no glitches on enable, disable or divisor change.
Divisor load:
- DIV_LD=1 captures the clamped DIV_IN into pending and sets DIV_PEND=1.
- Several loads before a boundary: the last one wins.
- In IDLE: pending is copied to d on the next edge; DIV_PEND is 1 for that single cycle.
- DIV_LD on the same cycle as a boundary: the new value governs the period starting at that boundary, and DIV_PEND stays 0.
- Otherwise DIV_PEND clears on the boundary edge that applies the value.
SYNC:
- Any channel in RUN or DRAIN takes cnt<=0, CLKOUT<=1, TICK<=1 and applies its pending divisor.
- DRAIN channels return to RUN only if EN=1.
- SYNC has priority over the boundary logic and is ignored by IDLE channels.
- Result: all running channels with equal d are exactly in phase.
Channel independence:
- Channels share only CLK, RST and SYNC; there is no cross-channel interaction.

Decomposition:
- Shared package/header clk_div_pkg: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2, and DIV_MIN=2.
- Sub-module clk_div_ch: one channel (counter, FSM, shadow divisor), instantiated NUM_CH times by a generate loop in clk_div_multi.

Test Plan:
- Reset, EN[0]=1, d=4: CLKOUT[0] pattern 1100 repeating (25 MHz); TICK[0] high once every 4 cycles, coincident with the CLKOUT rise.
- DIV_LD ch1 with DIV_IN=5 mid-period:
  - DIV_PEND[1]=1 until the boundary.
  - The current period stays 4 cycles, then pattern 11100 (3 high, 2 low).
  - DIV_IN=0 loads as d=2, giving pattern 10.
- EN[2] dropped at cnt=1, d=6: period finishes, 111000 completes, then CLKOUT=0 and no TICK. EN re-raised later: CLKOUT=1 one clock after.
- Channels d=4 and d=4, started 2 cycles apart, then SYNC pulse: both CLKOUT rise and TICK on the same edge, identical thereafter.
- RST asserted mid-high phase: CLKOUT, TICK and DIV_PEND go 0 immediately (before the next edge); after release the channel resumes at d=DIV_RST with EN held.
